// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter.
// Contents:
//   NPORTS      - number of requesters on the shared controller port
//   PORT_*      - requester index constants (ioctl upload, C64 bus, drive/aux)
//   arb_state_t - transaction sequencer state (IDLE, BUSY)
//   lowest_set  - lowest-index set bit of a port mask (index 0 wins ties)
package sdram_arb_pkg;

    localparam int NPORTS = 3;

    localparam logic [1:0] PORT_IOCTL = 2'd0;
    localparam logic [1:0] PORT_CPU   = 2'd1;
    localparam logic [1:0] PORT_AUX   = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Fixed priority encoder: port 0 beats port 1 beats port 2.
    function automatic logic [1:0] lowest_set(input logic [NPORTS-1:0] v);
        logic [1:0] r;
        r = PORT_IOCTL;
        if (v[0]) begin
            r = PORT_IOCTL;
        end else if (v[1]) begin
            r = PORT_CPU;
        end else if (v[2]) begin
            r = PORT_AUX;
        end else begin
            r = PORT_IOCTL;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection for the SDRAM port arbiter.
// Ports:
//   pending [NPORTS] in  - ports holding a buffered command
//   starved [NPORTS] in  - ports whose starvation counter reached the limit
//   idx     [2]      out - winning port index
//   valid   [1]      out - a winner exists (some port is pending)
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic [NPORTS-1:0] pending,
    input  logic [NPORTS-1:0] starved,
    output logic [1:0]        idx,
    output logic              valid
);

    logic [NPORTS-1:0] forced_s;

    assign forced_s = pending & starved;

    // Starved pending ports pre-empt the normal fixed priority.
    always_comb begin
        idx   = PORT_IOCTL;
        valid = 1'b0;
        if (forced_s != 3'b000) begin
            idx   = lowest_set(forced_s);
            valid = 1'b1;
        end else if (pending != 3'b000) begin
            idx   = lowest_set(pending);
            valid = 1'b1;
        end else begin
            idx   = PORT_IOCTL;
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port between three requesters
// (ioctl upload, C64 CPU/VIC bus, drive/aux). One-cycle strobes are buffered
// per port, a winner is chosen (fixed priority with anti-starvation), one
// transaction is sequenced at a time and a per-port completion pulse returns.
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   req_i/we_i          - per-port command strobe and write enable
//   addr_i/din_i        - per-port address / write data, port n at [n*W +: W]
//   ack_o, dout_o       - per-port completion pulse, read data with ack
//   err_o               - sticky per-port "strobed while still pending"
//   busy_o, grant_o     - transaction in flight, current/last granted port
//   sd_req/we/addr/din  - command to the SDRAM controller (level request)
//   sd_ack, sd_dout     - controller completion pulse and read data
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        req_i,
    input  logic [NPORTS-1:0]        we_i,
    input  logic [NPORTS*ADDR_W-1:0] addr_i,
    input  logic [NPORTS*DATA_W-1:0] din_i,
    output logic [NPORTS-1:0]        ack_o,
    output logic [DATA_W-1:0]        dout_o,
    output logic [NPORTS-1:0]        err_o,
    output logic                     busy_o,
    output logic [1:0]               grant_o,
    output logic                     sd_req,
    output logic                     sd_we,
    output logic [ADDR_W-1:0]        sd_addr,
    output logic [DATA_W-1:0]        sd_din,
    input  logic                     sd_ack,
    input  logic [DATA_W-1:0]        sd_dout
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [NPORTS-1:0] pending_r;
    logic [NPORTS-1:0] we_buf_r;
    logic [ADDR_W-1:0] addr_buf_r [NPORTS];
    logic [DATA_W-1:0] din_buf_r  [NPORTS];
    logic [7:0]        starve_r   [NPORTS];
    logic [NPORTS-1:0] starved_s;

    arb_state_t        state_r;
    arb_state_t        next_state_s;
    logic [1:0]        pick_idx_s;
    logic              pick_valid_s;
    logic              grant_edge_s;
    logic              done_s;

    // Flag ports whose starvation counter has hit the limit.
    always_comb begin
        starved_s = '0;
        for (int n = 0; n < NPORTS; n++) begin
            starved_s[n] = (starve_r[n] == STARVE_LIM);
        end
    end

    sdram_arb_pick u_pick (
        .pending (pending_r),
        .starved (starved_s),
        .idx     (pick_idx_s),
        .valid   (pick_valid_s)
    );

    // Command capture: a free port latches its strobe, a busy port flags an error.
    // Capture only happens with pending clear and release only with it set, so
    // the two updates never collide on the same port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= 3'b000;
            err_o     <= 3'b000;
            we_buf_r  <= 3'b000;
            for (int n = 0; n < NPORTS; n++) begin
                addr_buf_r[n] <= '0;
                din_buf_r[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < NPORTS; n++) begin
                if (req_i[n] && !pending_r[n]) begin
                    pending_r[n]  <= 1'b1;
                    we_buf_r[n]   <= we_i[n];
                    addr_buf_r[n] <= addr_i[n*ADDR_W +: ADDR_W];
                    din_buf_r[n]  <= din_i[n*DATA_W +: DATA_W];
                end else if (req_i[n]) begin
                    err_o[n] <= 1'b1;
                end
                if (done_s && (grant_o == 2'(n))) begin
                    pending_r[n] <= 1'b0;
                end
            end
        end
    end

    // Starvation counters move only when a grant is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NPORTS; n++) begin
                starve_r[n] <= 8'd0;
            end
        end else if (grant_edge_s) begin
            for (int n = 0; n < NPORTS; n++) begin
                if (pick_idx_s == 2'(n)) begin
                    starve_r[n] <= 8'd0;
                end else if (pending_r[n]) begin
                    if (starve_r[n] < STARVE_LIM) begin
                        starve_r[n] <= starve_r[n] + 8'd1;
                    end
                end else begin
                    starve_r[n] <= 8'd0;
                end
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Sequencer next-state logic; sd_ack outside BUSY is ignored.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = pick_valid_s ? BUSY : IDLE;
            BUSY:    next_state_s = sd_ack ? IDLE : BUSY;
            default: next_state_s = IDLE;
        endcase
    end

    // Sequencer event decode driving the registered outputs.
    always_comb begin
        grant_edge_s = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE:    grant_edge_s = pick_valid_s;
            BUSY:    done_s       = sd_ack;
            default: begin
                grant_edge_s = 1'b0;
                done_s       = 1'b0;
            end
        endcase
    end

    // Registered command and completion outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_req  <= 1'b0;
            sd_we   <= 1'b0;
            sd_addr <= '0;
            sd_din  <= '0;
            grant_o <= 2'd0;
            busy_o  <= 1'b0;
            ack_o   <= 3'b000;
            dout_o  <= '0;
        end else begin
            ack_o <= 3'b000;
            if (grant_edge_s) begin
                sd_req  <= 1'b1;
                sd_we   <= we_buf_r[pick_idx_s];
                sd_addr <= addr_buf_r[pick_idx_s];
                sd_din  <= din_buf_r[pick_idx_s];
                grant_o <= pick_idx_s;
                busy_o  <= 1'b1;
            end else if (done_s) begin
                sd_req <= 1'b0;
                busy_o <= 1'b0;
                ack_o  <= 3'b001 << grant_o;
                dout_o <= sd_dout;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter (STARVE_MAX = 3).
// A small controller model acks each command on its 4th sd_req cycle; a
// negedge monitor logs sd_req rises/falls and ack_o pulses with cycle stamps.
module tb_sdram_port_arbiter;

    localparam int AW      = 25;
    localparam int DW      = 8;
    localparam int SMAX    = 3;
    localparam int ACK_DLY = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      req_i;
    logic [2:0]      we_i;
    logic [3*AW-1:0] addr_i;
    logic [3*DW-1:0] din_i;
    logic [2:0]      ack_o;
    logic [DW-1:0]   dout_o;
    logic [2:0]      err_o;
    logic            busy_o;
    logic [1:0]      grant_o;
    logic            sd_req;
    logic            sd_we;
    logic [AW-1:0]   sd_addr;
    logic [DW-1:0]   sd_din;
    logic            sd_ack = 1'b0;
    logic [DW-1:0]   sd_dout = 8'h00;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .din_i(din_i), .ack_o(ack_o), .dout_o(dout_o),
        .err_o(err_o), .busy_o(busy_o), .grant_o(grant_o),
        .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_din(sd_din),
        .sd_ack(sd_ack), .sd_dout(sd_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model
    logic       ctl_en    = 1'b1;
    logic       ctl_force = 1'b0;
    logic [7:0] ctl_data  = 8'hA5;
    int         ctl_cnt   = 0;
    int         ctl_ack_cyc = 0;

    always @(negedge clk) begin
        if (ctl_force) begin
            sd_ack  <= 1'b1;
            sd_dout <= 8'h5A;
        end else if (ctl_en && sd_req && !sd_ack) begin
            if (ctl_cnt == ACK_DLY - 1) begin
                sd_ack      <= 1'b1;
                sd_dout     <= ctl_data;
                ctl_cnt     <= 0;
                ctl_ack_cyc <= cyc;
            end else begin
                ctl_cnt <= ctl_cnt + 1;
            end
        end else begin
            sd_ack  <= 1'b0;
            ctl_cnt <= 0;
        end
    end

    // Event monitor
    int            req_cyc[$];
    logic [1:0]    req_grant[$];
    logic [DW-1:0] req_din[$];
    logic [AW-1:0] req_addr[$];
    logic          req_we[$];
    int            fall_cyc[$];
    int            ack_cyc[$];
    logic [2:0]    ack_vec[$];
    logic          prev_req = 1'b0;

    always @(negedge clk) begin
        if (sd_req && !prev_req) begin
            req_cyc.push_back(cyc);
            req_grant.push_back(grant_o);
            req_din.push_back(sd_din);
            req_addr.push_back(sd_addr);
            req_we.push_back(sd_we);
        end
        if (!sd_req && prev_req) fall_cyc.push_back(cyc);
        if (ack_o != 3'b000) begin
            ack_cyc.push_back(cyc);
            ack_vec.push_back(ack_o);
        end
        prev_req <= sd_req;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        req_cyc.delete(); req_grant.delete(); req_din.delete();
        req_addr.delete(); req_we.delete(); fall_cyc.delete();
        ack_cyc.delete(); ack_vec.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        req_i = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_log();
    endtask

    task automatic strobe(input logic [2:0] mask, input logic [2:0] we,
                          input logic [3*AW-1:0] addr, input logic [3*DW-1:0] din,
                          output int t);
        @(negedge clk);
        req_i  = mask;
        we_i   = we;
        addr_i = addr;
        din_i  = din;
        t      = cyc;
        @(negedge clk);
        req_i = 3'b000;
    endtask

    task automatic wait_ack(input int budget, output logic [2:0] vec, output int c);
        vec = 3'b000;
        c   = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack_o != 3'b000) begin
                vec = ack_o;
                c   = cyc;
                break;
            end
        end
    endtask

    task automatic wait_ack_count(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (ack_cyc.size() >= n) break;
            @(negedge clk);
        end
    endtask

    initial begin
        int         t, a1, a2;
        logic [2:0] vec, vec2;

        reset = 1'b1; req_i = 3'b000; we_i = 3'b000; addr_i = '0; din_i = '0;
        repeat (3) @(negedge clk);
        check("rst_sd_req", 64'(sd_req), 64'd0);
        check("rst_busy",   64'(busy_o), 64'd0);
        check("rst_grant",  64'(grant_o), 64'd0);
        check("rst_ack",    64'(ack_o), 64'd0);
        check("rst_err",    64'(err_o), 64'd0);
        check("rst_dout",   64'(dout_o), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        clear_log();

        // Single read on port 1
        ctl_data = 8'hA5;
        strobe(3'b010, 3'b000, {25'h0, 25'h0001000, 25'h0}, 24'h0, t);
        wait_ack(40, vec, a1);
        check("t1_ack_vec", 64'(vec), 64'h2);
        check("t1_dout", 64'(dout_o), 64'hA5);
        @(negedge clk);
        check("t1_ack_one_cycle", 64'(ack_o), 64'd0);
        check("t1_req_low", 64'(sd_req), 64'd0);
        check("t1_req_latency", 64'(req_cyc[0]), 64'(t + 2));
        check("t1_grant", 64'(req_grant[0]), 64'd1);
        check("t1_grant_o", 64'(grant_o), 64'd1);
        check("t1_addr", 64'(req_addr[0]), 64'h1000);
        check("t1_we", 64'(req_we[0]), 64'd0);
        check("t1_ack_latency", 64'(ack_cyc[0]), 64'(ctl_ack_cyc + 1));
        check("t1_fall_latency", 64'(fall_cyc[0]), 64'(ctl_ack_cyc + 1));

        // Simultaneous strobes on all ports
        clear_log();
        ctl_data = 8'h3C;
        strobe(3'b111, 3'b000, {25'h300, 25'h200, 25'h100}, {8'h33, 8'h22, 8'h11}, t);
        wait_ack_count(3, 80);
        repeat (10) @(negedge clk);
        check("t2_ack_count", 64'(ack_cyc.size()), 64'd3);
        check("t2_req_count", 64'(req_cyc.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_grant%0d", i), 64'(req_grant[i]), 64'(i));
            check($sformatf("t2_ackvec%0d", i), 64'(ack_vec[i]), 64'(3'b001 << i));
        end
        for (int i = 1; i < 3; i++) begin
            check($sformatf("t2_idle_gap%0d", i), 64'(req_cyc[i] - fall_cyc[i-1]), 64'd1);
            check($sformatf("t2_regrant%0d", i), 64'(req_cyc[i]), 64'(ack_cyc[i-1] + 1));
        end

        // Starvation: ports 0 and 1 keep re-strobing, port 2 waits
        apply_reset();
        strobe(3'b111, 3'b000, {25'h30, 25'h20, 25'h10}, 24'h0, t);
        for (int k = 0; k < 3; k++) begin
            wait_ack(60, vec, a1);
            if (vec[0] || vec[1]) begin
                req_i = vec & 3'b011;
                @(negedge clk);
                req_i = 3'b000;
            end
        end
        wait_ack_count(6, 200);
        repeat (5) @(negedge clk);
        check("t3_grant0", 64'(req_grant[0]), 64'd0);
        check("t3_grant1", 64'(req_grant[1]), 64'd1);
        check("t3_grant2", 64'(req_grant[2]), 64'd0);
        check("t3_grant3_forced", 64'(req_grant[3]), 64'd2);
        check("t3_ack_count", 64'(ack_cyc.size()), 64'd6);
        check("t3_err", 64'(err_o), 64'd0);

        // Double strobe on port 2
        apply_reset();
        @(negedge clk);
        req_i = 3'b100; we_i = 3'b100; addr_i = {25'h0ABCD, 50'h0}; din_i = {8'h11, 16'h0};
        @(negedge clk);
        din_i = {8'h22, 16'h0};
        @(negedge clk);
        req_i = 3'b000;
        wait_ack_count(1, 60);
        repeat (10) @(negedge clk);
        check("t4_err", 64'(err_o), 64'h4);
        check("t4_sd_din", 64'(req_din[0]), 64'h11);
        check("t4_sd_we", 64'(req_we[0]), 64'd1);
        check("t4_req_count", 64'(req_cyc.size()), 64'd1);
        check("t4_ack_count", 64'(ack_cyc.size()), 64'd1);
        check("t4_ack_vec", 64'(ack_vec[0]), 64'h4);

        // Reset in the middle of a transaction
        apply_reset();
        ctl_en = 1'b0;
        strobe(3'b011, 3'b000, {25'h0, 25'h222, 25'h111}, 24'h0, t);
        for (int i = 0; i < 20; i++) begin
            if (sd_req) break;
            @(negedge clk);
        end
        check("t5_req_before", 64'(sd_req), 64'd1);
        reset = 1'b1;
        #1;
        check("t5_req_drop", 64'(sd_req), 64'd0);
        check("t5_busy_drop", 64'(busy_o), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_log();
        @(posedge clk); #1 ctl_force = 1'b1;
        @(posedge clk); #1 ctl_force = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_no_req", 64'(req_cyc.size()), 64'd0);
        check("t5_no_ack", 64'(ack_cyc.size()), 64'd0);
        check("t5_dout", 64'(dout_o), 64'd0);
        check("t5_err", 64'(err_o), 64'd0);
        ctl_en = 1'b1;

        // Back-to-back on port 1: re-strobe in its own ack cycle
        apply_reset();
        ctl_data = 8'h77;
        strobe(3'b010, 3'b010, {25'h0, 25'h1ABCDEF, 25'h0}, {8'h0, 8'h99, 8'h0}, t);
        wait_ack(40, vec, a1);
        req_i = 3'b010; we_i = 3'b010; din_i = {8'h0, 8'h55, 8'h0};
        @(negedge clk);
        req_i = 3'b000;
        wait_ack(60, vec2, a2);
        repeat (5) @(negedge clk);
        check("t6_ack1", 64'(vec), 64'h2);
        check("t6_ack2", 64'(vec2), 64'h2);
        check("t6_req2_latency", 64'(req_cyc[1]), 64'(a1 + 2));
        check("t6_din2", 64'(req_din[1]), 64'h55);
        check("t6_err", 64'(err_o), 64'd0);
        check("t6_ack_count", 64'(ack_cyc.size()), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
